// File: rtl/acoustics_pkg.sv
// Shared types and constants for the ADC sample packetizer.
// Frame layout: header, four channel-tagged 12-bit samples split hi/lo, XOR checksum.
package acoustics_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_e;

  localparam logic [7:0] CMD_START      = 8'h53;
  localparam logic [7:0] CMD_STOP       = 8'h50;
  localparam int         FRAME_BYTES    = 10;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef struct packed {
    logic [11:0] ch1;
    logic [11:0] ch2;
    logic [11:0] ch3;
    logic [11:0] ch4;
  } frame_t;

  // Byte idx of the serialised frame; any idx past the payload returns the checksum.
  function automatic logic [7:0] frame_byte(input frame_t f, input logic [3:0] idx,
                                            input logic [7:0] hdr);
    logic [7:0] b [FRAME_BYTES-1];
    logic [7:0] cks;
    b[0] = hdr;
    b[1] = {4'h1, f.ch1[11:8]};
    b[2] = f.ch1[7:0];
    b[3] = {4'h2, f.ch2[11:8]};
    b[4] = f.ch2[7:0];
    b[5] = {4'h3, f.ch3[11:8]};
    b[6] = f.ch3[7:0];
    b[7] = {4'h4, f.ch4[11:8]};
    b[8] = f.ch4[7:0];
    cks = 8'h00;
    for (int i = 0; i < FRAME_BYTES - 1; i++) begin
      cks = cks ^ b[i];
    end
    return (idx >= 4'(FRAME_BYTES - 1)) ? cks : b[idx];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; pop_data is valid combinationally while !empty.
// Push is refused when full unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en, rd_en;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_en && !rd_en)      count_d = count_q + CNT_W'(1);
    else if (!wr_en && rd_en) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sample_packetizer.sv
// Buffers 4-channel ADC frames and serialises each as 10 UART bytes; first tx_send 3 cycles after capture.
// Waits for tx_ready low-then-high between bytes; drops samples (sticky overflow) when the FIFO is full.
module sample_packetizer
  import acoustics_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] HEADER     = DEFAULT_HEADER
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        sample_valid,
  input  logic [11:0] ch1,
  input  logic [11:0] ch2,
  input  logic [11:0] ch3,
  input  logic [11:0] ch4,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_send,
  output logic [7:0]  tx_byte,
  output logic        data_logging,
  output logic        overflow,
  output logic [4:0]  fifo_level
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 between 2 and 16");
  end

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        seen_low_q, seen_low_d;
  frame_t      frame_q, frame_d;
  logic        tx_send_q, tx_send_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        logging_q, logging_d;
  logic        overflow_q, overflow_d;

  logic             push_req, pop;
  logic [47:0]      pop_data;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign push_req = sample_valid && logging_q;
  assign pop      = (state_q == LOAD);

  sync_fifo #(
    .WIDTH (48),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_b   (reset_b),
    .push      (push_req),
    .push_data ({ch1, ch2, ch3, ch4}),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seen_low_d = seen_low_q;
    frame_d    = frame_q;
    tx_send_d  = 1'b0;
    tx_byte_d  = tx_byte_q;
    logging_d  = logging_q;
    overflow_d = overflow_q;

    if (rx_ready) begin
      if (rx_data == CMD_START) begin
        logging_d  = 1'b1;
        overflow_d = 1'b0;
      end else if (rx_data == CMD_STOP) begin
        logging_d = 1'b0;
      end
    end
    // A drop in the same cycle as 'S' still leaves overflow set.
    if (push_req && fifo_full && !pop) overflow_d = 1'b1;

    case (state_q)
      IDLE: if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        frame_d = frame_t'(pop_data);
        idx_d   = 4'd0;
        state_d = SEND;
      end
      SEND: if (tx_ready) begin
        tx_send_d  = 1'b1;
        tx_byte_d  = frame_byte(frame_q, idx_q, HEADER);
        seen_low_d = 1'b0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (!tx_ready) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          if (idx_q == 4'(FRAME_BYTES - 1)) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      seen_low_q <= 1'b0;
      frame_q    <= '0;
      tx_send_q  <= 1'b0;
      tx_byte_q  <= 8'h00;
      logging_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seen_low_q <= seen_low_d;
      frame_q    <= frame_d;
      tx_send_q  <= tx_send_d;
      tx_byte_q  <= tx_byte_d;
      logging_q  <= logging_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_send      = tx_send_q;
  assign tx_byte      = tx_byte_q;
  assign data_logging = logging_q;
  assign overflow     = overflow_q;
  assign fifo_level   = 5'(fifo_count);

endmodule

// File: tb/tb_sample_packetizer.sv
// Scoreboard bench: stimulus queues expected UART bytes, a negedge monitor pops and compares them.
// A small UART model drops tx_ready for three cycles after every tx_send.
module tb_sample_packetizer;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] ch1 = '0, ch2 = '0, ch3 = '0, ch4 = '0;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready;
  logic        tx_send;
  logic [7:0]  tx_byte;
  logic        data_logging;
  logic        overflow;
  logic [4:0]  fifo_level;

  int          checks = 0;
  int          failures = 0;
  int          n_sent = 0;
  int          busy = 0;
  logic        hold = 1'b0;
  logic        prev_send = 1'b0;
  logic [7:0]  exp_q [$];
  logic [7:0]  vec_main [9] = '{8'hA5, 8'h1A, 8'hBC, 8'h21, 8'h23, 8'h30, 8'h00, 8'h4F, 8'hFF};

  sample_packetizer #(.FIFO_DEPTH(8), .HEADER(8'hA5)) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .sample_valid (sample_valid),
    .ch1          (ch1),
    .ch2          (ch2),
    .ch3          (ch3),
    .ch4          (ch4),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .tx_ready     (tx_ready),
    .tx_send      (tx_send),
    .tx_byte      (tx_byte),
    .data_logging (data_logging),
    .overflow     (overflow),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  assign tx_ready = (busy == 0) && !hold;

  always @(negedge clk) begin
    if (tx_send) busy = 3;
    else if (busy > 0) busy = busy - 1;
  end

  // Monitor: every tx_send pulse must match the head of the expected-byte queue.
  always @(negedge clk) begin
    logic [7:0] e;
    if (tx_send) begin
      checks++;
      if (prev_send !== 1'b0) begin
        failures++;
        $display("FAIL tx_send_double_pulse actual=%b required=0 (previous cycle)", prev_send);
      end
      n_sent++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL tx_byte_unexpected actual=%02h required=no transmission", tx_byte);
      end else begin
        e = exp_q.pop_front();
        if (tx_byte !== e) begin
          failures++;
          $display("FAIL tx_byte actual=%02h required=%02h (byte %0d)", tx_byte, e, n_sent);
        end
      end
    end
    prev_send = tx_send;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic [7:0] cmd, input logic sv,
                       input logic [11:0] a, input logic [11:0] b,
                       input logic [11:0] c, input logic [11:0] d);
    @(negedge clk);
    rx_ready = cv; rx_data = cmd; sample_valid = sv;
    ch1 = a; ch2 = b; ch3 = c; ch4 = d;
    @(negedge clk);
    rx_ready = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic push_frame(input logic [11:0] a, input logic [11:0] b,
                            input logic [11:0] c, input logic [11:0] d);
    logic [7:0] bt [10];
    bt[0] = 8'hA5;
    bt[1] = {4'h1, a[11:8]}; bt[2] = a[7:0];
    bt[3] = {4'h2, b[11:8]}; bt[4] = b[7:0];
    bt[5] = {4'h3, c[11:8]}; bt[6] = c[7:0];
    bt[7] = {4'h4, d[11:8]}; bt[8] = d[7:0];
    bt[9] = 8'h00;
    for (int i = 0; i < 9; i++) bt[9] = bt[9] ^ bt[i];
    for (int i = 0; i < 10; i++) exp_q.push_back(bt[i]);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_sent(input int target, input string name);
    int n = 0;
    while (n_sent < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(name, (n_sent >= target), 1);
  endtask

  initial begin
    int lat;
    int base;
    logic [7:0] cks;

    // Reset values
    #3;
    chk("rst_tx_send", tx_send, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_logging", data_logging, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fifo_level", fifo_level, 0);
    repeat (2) @(negedge clk);
    reset_b = 1'b1;

    // Samples without 'S' are ignored
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b1, 12'h111, 12'h222, 12'h333, 12'h444);
    repeat (10) @(negedge clk);
    chk("nolog_fifo_level", fifo_level, 0);
    chk("nolog_logging", data_logging, 0);
    chk("nolog_sent", n_sent, 0);

    // Unrelated command byte changes nothing
    drive(1'b1, 8'h41, 1'b0, '0, '0, '0, '0);
    chk("other_cmd_logging", data_logging, 0);

    // 'S' with a sample in the same cycle: the sample is not captured
    drive(1'b1, 8'h53, 1'b1, 12'h555, 12'h666, 12'h777, 12'h888);
    chk("start_logging", data_logging, 1);
    repeat (4) @(negedge clk);
    chk("start_same_cycle_level", fifo_level, 0);
    chk("start_same_cycle_sent", n_sent, 0);

    // Main frame, checksum derived from the listed payload bytes
    cks = 8'h00;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(vec_main[i]);
      cks = cks ^ vec_main[i];
    end
    exp_q.push_back(cks);
    drive(1'b0, 8'h00, 1'b1, 12'hABC, 12'h123, 12'h000, 12'hFFF);
    lat = 1;
    while (!tx_send && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("first_tx_latency", lat, 4);
    wait_drain("main_frame_drain");
    chk("main_fifo_level", fifo_level, 0);

    // Fill with tx held off: one frame sits in the output registers, eight in the FIFO
    hold = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_frame(12'(16 * i + 1), 12'(16 * i + 2), 12'(16 * i + 3), 12'(16 * i + 4));
      drive(1'b0, 8'h00, 1'b1, 12'(16 * i + 1), 12'(16 * i + 2), 12'(16 * i + 3), 12'(16 * i + 4));
    end
    chk("fill_fifo_level", fifo_level, 8);
    chk("fill_no_overflow", overflow, 0);
    drive(1'b0, 8'h00, 1'b1, 12'hDEA, 12'hDBE, 12'hEF0, 12'h123);
    chk("full_fifo_level", fifo_level, 8);
    chk("full_overflow", overflow, 1);
    drive(1'b1, 8'h53, 1'b0, '0, '0, '0, '0);
    chk("restart_clears_overflow", overflow, 0);
    chk("restart_keeps_logging", data_logging, 1);
    hold = 1'b0;
    wait_drain("full_drain");

    // 'P' mid-frame with two frames queued: all 30 bytes still go out
    hold = 1'b1;
    push_frame(12'h0A1, 12'h0B2, 12'h0C3, 12'h0D4);
    drive(1'b0, 8'h00, 1'b1, 12'h0A1, 12'h0B2, 12'h0C3, 12'h0D4);
    push_frame(12'h9F0, 12'h8E1, 12'h7D2, 12'h6C3);
    drive(1'b0, 8'h00, 1'b1, 12'h9F0, 12'h8E1, 12'h7D2, 12'h6C3);
    push_frame(12'h345, 12'h678, 12'h9AB, 12'hCDE);
    drive(1'b0, 8'h00, 1'b1, 12'h345, 12'h678, 12'h9AB, 12'hCDE);
    repeat (4) @(negedge clk);
    chk("stop_prequeue_level", fifo_level, 2);
    base = n_sent;
    hold = 1'b0;
    wait_sent(base + 4, "stop_reach_byte3");
    drive(1'b1, 8'h50, 1'b0, '0, '0, '0, '0);
    chk("stop_logging", data_logging, 0);
    drive(1'b0, 8'h00, 1'b1, 12'h777, 12'h777, 12'h777, 12'h777);
    wait_drain("stop_drain");
    chk("stop_bytes_sent", n_sent - base, 30);
    chk("stop_fifo_level", fifo_level, 0);

    // Reset during byte 5 discards the rest of the frame
    drive(1'b1, 8'h53, 1'b0, '0, '0, '0, '0);
    push_frame(12'h246, 12'h8AC, 12'hE02, 12'h468);
    drive(1'b0, 8'h00, 1'b1, 12'h246, 12'h8AC, 12'hE02, 12'h468);
    base = n_sent;
    wait_sent(base + 6, "rst_reach_byte5");
    #2 reset_b = 1'b0;
    #1;
    chk("midrst_tx_send", tx_send, 0);
    chk("midrst_tx_byte", tx_byte, 0);
    chk("midrst_logging", data_logging, 0);
    exp_q.delete();
    @(negedge clk);
    reset_b = 1'b1;
    base = n_sent;
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1, 12'h321, 12'h321, 12'h321, 12'h321);
    repeat (60) @(negedge clk);
    chk("postrst_sent", n_sent - base, 0);
    chk("postrst_fifo_level", fifo_level, 0);
    drive(1'b1, 8'h53, 1'b0, '0, '0, '0, '0);
    push_frame(12'h135, 12'h79B, 12'hDF1, 12'h357);
    drive(1'b0, 8'h00, 1'b1, 12'h135, 12'h79B, 12'hDF1, 12'h357);
    wait_drain("postrst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
